// File: rtl/io_port_pkg.sv
// Shared state encodings and defaults for the programmed-I/O terminal port.
package io_port_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IN_EMPTY = 2'd0,
        IN_FULL  = 2'd1,
        IN_PEND  = 2'd2
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_CAPT = 2'd1,
        OUT_SEND = 2'd2,
        OUT_WAIT = 2'd3
    } out_state_e;

endpackage

// File: rtl/io_port_flag.sv
// Set/clear flag flop (FGI/FGO); a set in the same cycle as a clear keeps the flag high.
module io_flag #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    logic flag_q, flag_d;

    always_comb begin
        flag_d = flag_q;
        if (set_i)
            flag_d = 1'b1;
        else if (clr_i)
            flag_d = 1'b0;
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flag_q <= RST_VAL;
        else
            flag_q <= flag_d;
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/io_terminal_port.sv
// Device side of the INPR/OUTR + FGI/FGO handshake: keyboard in with a one-byte skid,
// display out with a print delay before FGO is re-raised.
module io_terminal_port
    import io_port_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int PRINT_CYCLES = 16,
    parameter int CNT_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fgi_clr,
    input  logic              fgo_clr,
    input  logic [DATA_W-1:0] outr_outdata,
    input  logic              ien_outdata,
    output logic [DATA_W-1:0] inpr_outdata,
    output logic              fgi_outdata,
    output logic              fgo_outdata,
    output logic              io_irq,
    output logic              io_error,
    input  logic [DATA_W-1:0] kbd_data,
    input  logic              kbd_valid,
    output logic              kbd_ready,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              disp_ready
);

    in_state_e         in_state_q, in_state_d;
    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              fgi_set;

    out_state_e        out_state_q, out_state_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              io_error_q, io_error_d;
    logic              fgo_set, fgo_clr_ok;

    logic kbd_xfer, disp_xfer;

    assign kbd_ready = (in_state_q != IN_PEND);
    assign kbd_xfer  = kbd_valid & kbd_ready;
    assign disp_xfer = disp_valid_q & disp_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        in_state_d = in_state_q;
        inpr_d     = inpr_q;
        pend_d     = pend_q;
        fgi_set    = 1'b0;
        unique case (in_state_q)
            IN_EMPTY: begin
                if (kbd_xfer) begin
                    inpr_d     = kbd_data;
                    fgi_set    = 1'b1;
                    in_state_d = IN_FULL;
                end
            end
            IN_FULL: begin
                if (kbd_xfer && fgi_clr) begin
                    // CPU consumes INPR as the next byte lands: replace it in place.
                    inpr_d  = kbd_data;
                    fgi_set = 1'b1;
                end else if (kbd_xfer) begin
                    pend_d     = kbd_data;
                    in_state_d = IN_PEND;
                end else if (fgi_clr) begin
                    in_state_d = IN_EMPTY;
                end
            end
            IN_PEND: begin
                if (fgi_clr) begin
                    inpr_d     = pend_q;
                    fgi_set    = 1'b1;
                    in_state_d = IN_FULL;
                end
            end
            default: in_state_d = IN_EMPTY;
        endcase
    end

    always_comb begin
        out_state_d  = out_state_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        cnt_d        = cnt_q;
        fgo_set      = 1'b0;
        fgo_clr_ok   = 1'b0;
        // An OUT while the display side is still busy is dropped but remembered.
        io_error_d   = io_error_q | (fgo_clr & (out_state_q != OUT_IDLE));
        unique case (out_state_q)
            OUT_IDLE: begin
                if (fgo_clr) begin
                    fgo_clr_ok  = 1'b1;
                    out_state_d = OUT_CAPT;
                end
            end
            OUT_CAPT: begin
                disp_data_d  = outr_outdata;
                disp_valid_d = 1'b1;
                out_state_d  = OUT_SEND;
            end
            OUT_SEND: begin
                if (disp_xfer) begin
                    disp_valid_d = 1'b0;
                    cnt_d        = CNT_W'(PRINT_CYCLES - 1);
                    out_state_d  = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (cnt_q == '0) begin
                    fgo_set     = 1'b1;
                    out_state_d = OUT_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_q   <= IN_EMPTY;
            inpr_q       <= '0;
            pend_q       <= '0;
            out_state_q  <= OUT_IDLE;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            cnt_q        <= '0;
            io_error_q   <= 1'b0;
        end else begin
            in_state_q   <= in_state_d;
            inpr_q       <= inpr_d;
            pend_q       <= pend_d;
            out_state_q  <= out_state_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            cnt_q        <= cnt_d;
            io_error_q   <= io_error_d;
        end
    end

    io_flag #(.RST_VAL(1'b0)) u_fgi (
        .clk    (clk),
        .reset  (reset),
        .set_i  (fgi_set),
        .clr_i  (fgi_clr),
        .flag_o (fgi_outdata)
    );

    io_flag #(.RST_VAL(1'b1)) u_fgo (
        .clk    (clk),
        .reset  (reset),
        .set_i  (fgo_set),
        .clr_i  (fgo_clr_ok),
        .flag_o (fgo_outdata)
    );

    assign inpr_outdata = inpr_q;
    assign disp_data    = disp_data_q;
    assign disp_valid   = disp_valid_q;
    assign io_error     = io_error_q;
    assign io_irq       = ien_outdata & (fgi_outdata | fgo_outdata);

endmodule
